pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Holds or bubbles the IF/ID, ID/EX, EX/MEM and
//  MEM/WB registers for three events: data-memory wait states, load-use hazards and taken branches.
//  Tracks outstanding memory accesses with a small FSM and a timeout. Keeps a saturating stall-cycle counter.
// PARAMETERS
//  MEM_TIMEOUT  255  max wait cycles for Mem_Ack before entering ERROR; 0 disables the timeout
//  CNT_WIDTH    16   width of Stall_Cycles
// PORTS
//  Clk             in   1   pipeline clock, rising edge
//  Reset_n         in   1   asynchronous, active-low reset
//  Mem_Req_MEM     in   1   load/store instruction present in MEM stage
//  Mem_Ack         in   1   data memory completes the access this cycle
//  Load_EX         in   1   instruction in EX is a load
//  rd_EX           in   5   destination register of the EX instruction
//  rs1_ID, rs2_ID  in   5   source registers of the ID instruction
//  Use_rs1_ID      in   1   ID instruction reads rs1
//  Use_rs2_ID      in   1   ID instruction reads rs2
//  Branch_Taken_EX in   1   branch/jump resolved taken in EX
//  Stall_IF        out  1   hold PC and IF/ID
//  Stall_ID        out  1   hold ID/EX
//  Stall_EX        out  1   hold EX/MEM
//  Flush_ID        out  1   load NOP into IF/ID
//  Bubble_EX       out  1   load NOP into ID/EX (Write_Enable and Mem_Req cleared)
//  Bubble_WB       out  1   force Write_Enable_WB=0 on the next MEM/WB capture
//  Mem_Busy        out  1   FSM in MEM_WAIT
//  Mem_Err         out  1   sticky; access timed out
//  Stall_Cycles    out  CNT_WIDTH  saturating count of cycles with Stall_IF=1
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, ERROR. The state register is updated on posedge Clk.
//  - All stall, flush and bubble outputs are combinational from the state and the inputs, so they act in the same cycle.
//  - Reset (Reset_n=0, asynchronous): state=RUN, Mem_Err=0, Stall_Cycles=0, wait counter=0.
//    All combinational outputs then follow the RUN equations.
//  - Reset may occur mid-MEM_WAIT. The access is abandoned and nothing is replayed.
//  - memwait = (state==RUN & Mem_Req_MEM & ~Mem_Ack) | (state==MEM_WAIT & ~Mem_Ack).
//  - loaduse = Load_EX & rd_EX!=0 & ((Use_rs1_ID & rs1_ID==rd_EX) | (Use_rs2_ID & rs2_ID==rd_EX)).
//  - Priority is ERROR > memwait > branch > loaduse.
//  - ERROR:
//    Stall_IF = Stall_ID = Stall_EX = Bubble_WB = 1. Flush_ID = Bubble_EX = 0.
//    The FSM leaves ERROR only on reset.
//  - memwait:
//    Stall_IF = Stall_ID = Stall_EX = Bubble_WB = 1. Flush_ID = Bubble_EX = 0.
//    A taken branch frozen in EX is serviced once the wait ends.
//  - else Branch_Taken_EX:
//    Flush_ID = Bubble_EX = 1. Stalls = 0.
//    A coincident loaduse is ignored because the ID instruction is squashed.
//  - else loaduse:
//    Stall_IF = 1, Bubble_EX = 1 for exactly one cycle. The load then advances, which clears the hazard.
//  - else all outputs = 0.
//  - FSM transitions:
//    RUN -> MEM_WAIT when Mem_Req_MEM & ~Mem_Ack.
//    Mem_Req_MEM & Mem_Ack in RUN is a zero-wait access and causes no stall.
//    MEM_WAIT -> RUN on the cycle Mem_Ack=1. Stalls drop in that same cycle.
//    MEM_WAIT -> ERROR when the wait counter reaches MEM_TIMEOUT-1 with Mem_Ack=0. Mem_Err is set on that edge.
//  - Wait counter: cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle.
//    Its width is clog2(MEM_TIMEOUT+1), with a minimum of 1.
//  - Mem_Ack in RUN without Mem_Req_MEM is ignored.
//  - Stall_Cycles increments when Stall_IF=1 and holds at all-ones, with no wrap.
//  - rd_EX=0 never creates a load-use hazard.
// TESTING
//  1 Zero-wait: Mem_Req_MEM=1 and Mem_Ack=1 in the same cycle -> all stalls 0, Mem_Busy=0, Stall_Cycles unchanged.
//  2 Three wait states: Req=1, Ack=0 for 3 cycles, then Ack=1
//    -> Stall_IF/ID/EX and Bubble_WB=1 for 3 cycles, 0 on the ack cycle, Stall_Cycles=3.
//  3 Load-use: Load_EX=1, rd_EX=5, rs2_ID=5, Use_rs2_ID=1 -> Stall_IF=1, Bubble_EX=1 for 1 cycle.
//    Repeat with rd_EX=0 -> no stall.
//  4 Branch plus load-use in the same cycle -> Flush_ID=1, Bubble_EX=1, Stall_IF=0.
//    Branch during memwait -> Flush_ID=0 until the ack cycle.
//  5 Timeout with MEM_TIMEOUT=4: Req=1, Ack never asserted -> Mem_Err=1 after 4 wait cycles and all stalls held.
//    Reset_n pulse -> RUN, Mem_Err=0, Stall_Cycles=0.
//  6 Saturation with CNT_WIDTH=4: force more than 20 stall cycles -> Stall_Cycles holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait FSM with timeout,
// load-use detection, taken-branch squash and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Mem_Req_MEM,
    input  logic                 Mem_Ack,
    input  logic                 Load_EX,
    input  logic [4:0]           rd_EX,
    input  logic [4:0]           rs1_ID,
    input  logic [4:0]           rs2_ID,
    input  logic                 Use_rs1_ID,
    input  logic                 Use_rs2_ID,
    input  logic                 Branch_Taken_EX,
    output logic                 Stall_IF,
    output logic                 Stall_ID,
    output logic                 Stall_EX,
    output logic                 Flush_ID,
    output logic                 Bubble_EX,
    output logic                 Bubble_WB,
    output logic                 Mem_Busy,
    output logic                 Mem_Err,
    output logic [CNT_WIDTH-1:0] Stall_Cycles
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // Only meaningful when the timeout is enabled; the compare is gated below.
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } state_e;

    state_e               state_q, state_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic memwait;
    logic loaduse;

    always_comb begin
        memwait = ((state_q == StRun) && Mem_Req_MEM && !Mem_Ack) ||
                  ((state_q == StMemWait) && !Mem_Ack);
        loaduse = Load_EX && (rd_EX != 5'd0) &&
                  ((Use_rs1_ID && (rs1_ID == rd_EX)) || (Use_rs2_ID && (rs2_ID == rd_EX)));
    end

    always_comb begin
        Stall_IF  = 1'b0;
        Stall_ID  = 1'b0;
        Stall_EX  = 1'b0;
        Flush_ID  = 1'b0;
        Bubble_EX = 1'b0;
        Bubble_WB = 1'b0;

        if (state_q == StError || memwait) begin
            Stall_IF  = 1'b1;
            Stall_ID  = 1'b1;
            Stall_EX  = 1'b1;
            Bubble_WB = 1'b1;
        end else if (Branch_Taken_EX) begin
            // The ID instruction is squashed, so a coincident load-use needs no stall.
            Flush_ID  = 1'b1;
            Bubble_EX = 1'b1;
        end else if (loaduse) begin
            Stall_IF  = 1'b1;
            Bubble_EX = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StRun: begin
                if (Mem_Req_MEM && !Mem_Ack) begin
                    state_d = StMemWait;
                    wait_d  = '0;
                end
            end
            StMemWait: begin
                if (Mem_Ack) begin
                    state_d = StRun;
                end else if ((MEM_TIMEOUT != 0) && (wait_q == WaitLast)) begin
                    state_d = StError;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StError: state_d = StError;
            default: state_d = StRun;
        endcase

        if (Stall_IF && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StRun;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Mem_Busy     = (state_q == StMemWait);
    assign Mem_Err      = err_q;
    assign Stall_Cycles = cnt_q;

endmodule
